register_file: RTL
==================

# register_file

- 32 x 32-bit MIPS general-purpose register file.
- Two combinational read ports supply the ALU's first operand and the store/second-operand path; one synchronous write port takes the ALU or memory write-back result.
- `$zero` (register 0) is hardwired to zero.
- After reset, a sequencer zeroes registers 1..31 one per cycle, so the array maps onto plain RAM without a parallel reset. `Ready` is low during this clear.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Read_Reg_1  in  ADDR_W  index for read port 1 (rs)
- Read_Reg_2  in  ADDR_W  index for read port 2 (rt)
- Write_Reg  in  ADDR_W  write index (rd/rt, after RegDst mux)
- Write_Data  in  DATA_W  write-back value
- Reg_Write  in  1  write enable
- Read_Data_1  out  DATA_W  contents of Read_Reg_1
- Read_Data_2  out  DATA_W  contents of Read_Reg_2
- Ready  out  1  high once the post-reset clear has finished; the pipeline control stalls the PC while it is low

## Operation
- Clear FSM states:
  - CLEAR (reset state): each cycle writes 0 to register `clr_cnt`, then increments `clr_cnt`. When `clr_cnt` is 31 and that write is done, the FSM moves to RUN.
  - RUN: normal operation; the FSM stays here until reset.
- `reset` high at any edge, including in the middle of a clear, forces CLEAR with `clr_cnt` = 1.
- Reads are combinational, with zero latency.
  - Index 0 always returns 0.
  - In CLEAR, both read ports return 0.
- Writes:
  - A write occurs on a rising edge when the FSM is in RUN, `Reg_Write` = 1 and `Write_Reg` != 0.
  - Writes to index 0 are discarded.
  - Writes presented during CLEAR are dropped, not queued.
- Simultaneous read and write of the same index in RUN: see Configuration.
- Two read ports on the same index return identical data.
- Arithmetic: `clr_cnt` is ADDR_W bits wide. Its terminal value 31 is detected explicitly; it is never allowed to wrap to 0.

## Timing
- Reset values: `Ready` = 0; `Read_Data_1` = `Read_Data_2` = 0 (forced while in CLEAR); FSM = CLEAR; `clr_cnt` = 1.
- Clear duration: `Ready` rises exactly 31 rising edges after the first edge with `reset` low.
- Write latency: data written at edge N is visible on the read ports after edge N, with no bypass needed.
- Read-to-output delay is combinational only; no clock edge is involved.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-first behaviour.
  - When `Reg_Write` = 1, in RUN, `Write_Reg` != 0, and `Write_Reg` equals a read index, that read port returns `Write_Data` in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Read-first behaviour.
  - The read port returns the stored (old) value until the edge.
- Index 0 returns 0 in both builds.

## Structure
- Shared package `mips_pkg`:
  - DATA_W, ADDR_W and NUM_REGS constants.
  - `regfile_state_t` enum {CLEAR, RUN}.
  - REG_ZERO = 5'd0.
- One sub-module: `regfile_clear_seq`.
  - Contains the FSM and `clr_cnt`.
  - Outputs the clear write enable, clear index and `Ready`.
- The array, write mux (clear vs. normal) and read/bypass logic stay in `register_file`.

## Test plan
- Reset clear:
  - Stimulus: preload garbage by forcing the array; hold `reset` 2 cycles, then release.
  - Required: `Ready` = 0 for 31 edges, then 1; reading indices 1..31 then returns 0.
- Write/read:
  - Stimulus: in RUN, write 50 to reg 8 and 20 to reg 9; set `Read_Reg_1`=8, `Read_Reg_2`=9.
  - Required: `Read_Data_1`=50, `Read_Data_2`=20.
- Register 0:
  - Stimulus: write 32'hDEADBEEF to reg 0, then read reg 0 on both ports.
  - Required: 0 on both ports, in the write cycle and afterwards.
- Same-cycle read/write:
  - Stimulus: reg 8 = 50; write 55 to reg 8 while reading reg 8.
  - Required in the write cycle: 55 with REGFILE_BYPASS_EN, 50 without. Required after the edge: 55 in both builds.
- Reset mid-clear:
  - Stimulus: assert `reset` 10 cycles into a clear.
  - Required: `Ready` stays 0; the clear restarts from reg 1 and completes 31 edges after `reset` falls.
- Write during clear:
  - Stimulus: `Reg_Write`=1, `Write_Reg`=5, `Write_Data`=7 in cycle 3 of the clear.
  - Required: after `Ready`, reg 5 reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file.
package mips_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR,
      RUN
   } regfile_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks registers 1..2**ADDR_W-1 writing zero, then raises ready.
module regfile_clear_seq #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_idx_o,
   output logic              ready_o
);
   import mips_pkg::*;

   localparam logic [ADDR_W-1:0] LastIdx  = '1;
   localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(1);

   regfile_state_t    state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= CLEAR;
         clr_cnt_q <= FirstIdx;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Terminal index is caught explicitly so the counter never wraps back to $zero.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         CLEAR: begin
            if (clr_cnt_q == LastIdx) begin
               state_d = RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + FirstIdx;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   assign clr_we_o  = (state_q == CLEAR);
   assign clr_idx_o = clr_cnt_q;
   assign ready_o   = (state_q == RUN);

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file, two combinational reads, one synchronous write, $zero hardwired.
// Define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module register_file #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Read_Reg_1,
   input  logic [ADDR_W-1:0] Read_Reg_2,
   input  logic [ADDR_W-1:0] Write_Reg,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic              Reg_Write,
   output logic [DATA_W-1:0] Read_Data_1,
   output logic [DATA_W-1:0] Read_Data_2,
   output logic              Ready
);
   import mips_pkg::*;

   localparam int unsigned       NumRegs = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_q [NumRegs];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              user_we;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_data;

   regfile_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk_i     (clk),
      .reset_i   (reset),
      .clr_we_o  (clr_we),
      .clr_idx_o (clr_idx),
      .ready_o   (Ready)
   );

   assign user_we = Ready && Reg_Write && (Write_Reg != ZeroIdx);

   // Clear sequencer owns the single write port until it hands over.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = Write_Reg;
      wr_data = Write_Data;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_idx  = clr_idx;
         wr_data = '0;
      end else if (user_we) begin
         wr_en = 1'b1;
      end
   end

   // No reset on the array so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         regs_q[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      Read_Data_1 = regs_q[Read_Reg_1];
      if (!Ready || (Read_Reg_1 == ZeroIdx)) begin
         Read_Data_1 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (user_we && (Write_Reg == Read_Reg_1)) begin
         Read_Data_1 = Write_Data;
`endif
      end
   end

   always_comb begin
      Read_Data_2 = regs_q[Read_Reg_2];
      if (!Ready || (Read_Reg_2 == ZeroIdx)) begin
         Read_Data_2 = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (user_we && (Write_Reg == Read_Reg_2)) begin
         Read_Data_2 = Write_Data;
`endif
      end
   end

endmodule
